// File: rtl/p66b_tx_scrambler.sv
// 64b/66b transmit scrambler.
// Takes 66-bit blocks from upstream, substitutes an idle block when nothing is
// offered and an error block when the sync header is invalid, then scrambles
// the 64-bit payload with the self-synchronous polynomial 1 + x^39 + x^58.
// The sync header is passed through unscrambled. The downstream gearbox pulls
// one block per M_READY cycle, and M_DATA always holds a valid block.
module p66b_tx_scrambler #(
    parameter logic [57:0] SEED     = 58'h3ff_ffff_ffff_ffff,
    parameter bit          OPT_IDLE = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_bypass,
    input  logic        S_VALID,
    output logic        S_READY,
    input  logic [65:0] S_DATA,
    input  logic        M_READY,
    output logic [65:0] M_DATA,
    output logic [31:0] o_ninserted,
    output logic [15:0] o_nerrors
);

    localparam logic [63:0] IDLE_PAYLOAD = 64'h0000_0000_0000_001E;
    localparam logic [63:0] ERR_PAYLOAD  = {{8{7'h1E}}, 8'h1E};
    localparam logic [65:0] IDLE_BLOCK   = {IDLE_PAYLOAD, 2'b01};

    logic [57:0] r_state;
    logic [65:0] r_mdata;
    logic [31:0] r_ninserted;
    logic [15:0] r_nerrors;

    logic        w_badHdr;
    logic [1:0]  w_blockHdr;
    logic [63:0] w_blockPay;
    logic [63:0] w_scrPay;
    logic [57:0] w_nextState;

    assign S_READY     = M_READY && !i_reset;
    assign M_DATA      = r_mdata;
    assign o_ninserted = r_ninserted;
    assign o_nerrors   = r_nerrors;

    assign w_badHdr = (S_DATA[1:0] == 2'b00) || (S_DATA[1:0] == 2'b11);

    // Choose the block to send: the offered block, an error block when its
    // header is invalid, or an idle block when nothing is offered. With
    // OPT_IDLE=0 the idle block is still sent so M_DATA stays meaningful;
    // only the insertion count is suppressed.
    always_comb begin
        w_blockHdr = IDLE_BLOCK[1:0];
        w_blockPay = IDLE_PAYLOAD;
        if (S_VALID) begin
            if (w_badHdr) begin
                w_blockHdr = 2'b01;
                w_blockPay = ERR_PAYLOAD;
            end else begin
                w_blockHdr = S_DATA[1:0];
                w_blockPay = S_DATA[65:2];
            end
        end
    end

    // Unrolled scrambler: e[0..57] is the stored history (e[0] oldest), and
    // each payload bit k produces e[58+k] = d[k] ^ e[k+19] ^ e[k].
    always_comb begin : scramble
        logic [121:0] e;
        e          = '0;
        e[57:0]    = r_state;
        for (int k = 0; k < 64; k++) begin
            e[58 + k] = w_blockPay[k] ^ e[k + 19] ^ e[k];
        end
        w_scrPay    = e[121:58];
        w_nextState = e[121:64];
    end

    // Register the outgoing block, scrambler state and counters; everything
    // freezes while the gearbox is not taking data.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= SEED;
            r_mdata     <= IDLE_BLOCK;
            r_ninserted <= '0;
            r_nerrors   <= '0;
        end else if (M_READY) begin
            if (i_bypass) begin
                r_mdata <= {w_blockPay, w_blockHdr};
            end else begin
                r_mdata <= {w_scrPay, w_blockHdr};
                r_state <= w_nextState;
            end
            if (S_VALID && w_badHdr) begin
                r_nerrors <= r_nerrors + 16'd1;
            end
            if (!S_VALID && OPT_IDLE) begin
                r_ninserted <= r_ninserted + 32'd1;
            end
        end
    end

endmodule
